// File: rtl/equation_pkg.sv
// Shared constants and helpers for the equation evaluator.
// The truth table encodes z = (x1 & ~x2) | (x3 & x4) | (x2 & x5),
// indexed by idx = {x1,x2,x3,x4,x5} (x1 is the MSB).
package equation_pkg;

  localparam int IDX_W = 5;
  localparam int CNT_W = 3;

  // Bits 0-7   (x1=0,x2=0): only x3&x4 -> idx 6,7        -> 8'hC0
  // Bits 8-15  (x1=0,x2=1): x5 or x3&x4 -> 9,11,13,14,15 -> 8'hEA
  // Bits 16-23 (x1=1,x2=0): x1&~x2 always true            -> 8'hFF
  // Bits 24-31 (x1=1,x2=1): same shape as bits 8-15       -> 8'hEA
  localparam logic [31:0] EQ_TT = 32'hEAFF_EAC0;

  // Number of ones among the five equation inputs (0..5).
  function automatic logic [CNT_W-1:0] popcount5(input logic [IDX_W-1:0] v);
    logic [CNT_W-1:0] cnt;
    cnt = '0;
    for (int i = 0; i < IDX_W; i++) begin
      cnt = cnt + {{(CNT_W-1){1'b0}}, v[i]};
    end
    return cnt;
  endfunction

endpackage

// File: rtl/equation_lut.sv
// Combinational 32-entry single-bit lookup: returns tt[idx].
module equation_lut
  import equation_pkg::*;
(
  input  logic [IDX_W-1:0] idx,
  input  logic [31:0]      tt,
  output logic             bit_o
);

  // Select the table bit addressed by the minterm index.
  always_comb begin
    bit_o = tt[idx];
  end

endmodule

// File: rtl/equation.sv
// Registered evaluator of z = (x1 & ~x2) | (x3 & x4) | (x2 & x5) with a
// matching valid flag and a population count of the sampled inputs.
// Optional build macro EQUATION_PROG_EN adds a run-time loadable truth table
// (cfg_we / cfg_tt); without it the constant EQ_TT is used.
module equation
  import equation_pkg::*;
#(
  parameter logic RESET_Z   = 1'b0,
  parameter bit   HOLD_IDLE = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
`ifdef EQUATION_PROG_EN
  input  logic             cfg_we,
  input  logic [31:0]      cfg_tt,
`endif
  input  logic             in_valid,
  input  logic             x1,
  input  logic             x2,
  input  logic             x3,
  input  logic             x4,
  input  logic             x5,
  output logic             z,
  output logic             out_valid,
  output logic [CNT_W-1:0] ones_cnt
);

  logic [IDX_W-1:0] idx;
  logic [31:0]      tt_sel;
  logic             lut_bit;

  logic             z_d, z_q;
  logic             out_valid_d, out_valid_q;
  logic [CNT_W-1:0] ones_cnt_d, ones_cnt_q;

`ifdef EQUATION_PROG_EN
  logic [31:0] tt_d, tt_q;

  // Next table value: a write takes effect at the edge, so evaluations in
  // the same cycle still see the previous table.
  always_comb begin
    tt_d = tt_q;
    if (cfg_we) begin
      tt_d = cfg_tt;
    end
  end

  // Table register, restored to the fixed equation on reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tt_q <= EQ_TT;
    end else begin
      tt_q <= tt_d;
    end
  end

  assign tt_sel = tt_q;
`else
  assign tt_sel = EQ_TT;
`endif

  assign idx = {x1, x2, x3, x4, x5};

  equation_lut u_lut (
    .idx   (idx),
    .tt    (tt_sel),
    .bit_o (lut_bit)
  );

  // Next-result logic: capture on in_valid, otherwise hold or clear.
  always_comb begin
    out_valid_d = in_valid;
    if (in_valid) begin
      z_d        = lut_bit;
      ones_cnt_d = popcount5(idx);
    end else if (HOLD_IDLE) begin
      z_d        = z_q;
      ones_cnt_d = ones_cnt_q;
    end else begin
      z_d        = RESET_Z;
      ones_cnt_d = '0;
    end
  end

  // Result registers; reset dominates in_valid.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      z_q         <= RESET_Z;
      out_valid_q <= 1'b0;
      ones_cnt_q  <= '0;
    end else begin
      z_q         <= z_d;
      out_valid_q <= out_valid_d;
      ones_cnt_q  <= ones_cnt_d;
    end
  end

  assign z         = z_q;
  assign out_valid = out_valid_q;
  assign ones_cnt  = ones_cnt_q;

endmodule

// File: tb/tb_equation.sv
// Directed self-checking bench for the equation evaluator.
// Build with EQUATION_PROG_EN defined to also cover the loadable table.
module tb_equation;

  localparam logic TB_RESET_Z   = 1'b0;
  localparam bit   TB_HOLD_IDLE = 1'b1;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic       x1, x2, x3, x4, x5;
  logic       z;
  logic       out_valid;
  logic [2:0] ones_cnt;
`ifdef EQUATION_PROG_EN
  logic        cfg_we;
  logic [31:0] cfg_tt;
`endif

  int n_vec = 0;
  int n_err = 0;

  equation #(
    .RESET_Z   (TB_RESET_Z),
    .HOLD_IDLE (TB_HOLD_IDLE)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
`ifdef EQUATION_PROG_EN
    .cfg_we    (cfg_we),
    .cfg_tt    (cfg_tt),
`endif
    .in_valid  (in_valid),
    .x1        (x1),
    .x2        (x2),
    .x3        (x3),
    .x4        (x4),
    .x5        (x5),
    .z         (z),
    .out_valid (out_valid),
    .ones_cnt  (ones_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison point: counts and reports mismatches.
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Closed-form reference, independent of any truth-table constant.
  function automatic logic ref_z(input logic [4:0] v);
    logic a1, a2, a3, a4, a5;
    {a1, a2, a3, a4, a5} = v;
    return (a1 & ~a2) | (a3 & a4) | (a2 & a5);
  endfunction

  function automatic logic [31:0] ref_cnt(input logic [4:0] v);
    return 32'(v[0]) + 32'(v[1]) + 32'(v[2]) + 32'(v[3]) + 32'(v[4]);
  endfunction

  // Drive one input cycle at the falling edge, then wait until the
  // following falling edge so the registered result is visible.
  task automatic step(input logic valid, input logic [4:0] v);
    in_valid = valid;
    {x1, x2, x3, x4, x5} = v;
    $display("txn valid=%0b x=%05b", valid, v);
    @(negedge clk);
  endtask

  typedef struct {
    logic [4:0] v;
    logic       ez;
    logic [2:0] ecnt;
  } vec_t;

  vec_t dir [11];

  logic r2, r3;
  int   two, three;

  initial begin
    dir[0]  = '{5'b00000, 1'b0, 3'd0};
    dir[1]  = '{5'b00001, 1'b0, 3'd1};
    dir[2]  = '{5'b00010, 1'b0, 3'd1};
    dir[3]  = '{5'b00100, 1'b0, 3'd1};
    dir[4]  = '{5'b01000, 1'b0, 3'd1};
    dir[5]  = '{5'b10000, 1'b1, 3'd1};
    dir[6]  = '{5'b11111, 1'b1, 3'd5};
    dir[7]  = '{5'b00110, 1'b1, 3'd2};
    dir[8]  = '{5'b01001, 1'b1, 3'd2};
    dir[9]  = '{5'b11000, 1'b0, 3'd2};
    dir[10] = '{5'b10001, 1'b1, 3'd2};

    rst_n = 1'b0;
    in_valid = 1'b0;
    {x1, x2, x3, x4, x5} = 5'b0;
`ifdef EQUATION_PROG_EN
    cfg_we = 1'b0;
    cfg_tt = '0;
`endif

    // Reset with valid input present for two edges: reset must win.
    @(negedge clk);
    step(1'b1, 5'b11111);
    step(1'b1, 5'b11111);
    check("reset_z", 32'(z), 32'(TB_RESET_Z));
    check("reset_valid", 32'(out_valid), 32'd0);
    check("reset_cnt", 32'(ones_cnt), 32'd0);
    rst_n = 1'b1;

    // Directed vectors with hand-computed results.
    for (int i = 0; i < 11; i++) begin
      step(1'b1, dir[i].v);
      check($sformatf("dir_z_%05b", dir[i].v), 32'(z), 32'(dir[i].ez));
      check($sformatf("dir_cnt_%05b", dir[i].v), 32'(ones_cnt), 32'(dir[i].ecnt));
      check($sformatf("dir_valid_%05b", dir[i].v), 32'(out_valid), 32'd1);
    end

    // Truncation of wider environment values to 1 bit.
    two = 2;
    three = 3;
    r2 = 1'(two);
    r3 = 1'(three);
    step(1'b1, {1'b0, r2, r3, 1'b0, 1'b0});
    check("trunc_z", 32'(z), 32'd0);
    check("trunc_cnt", 32'(ones_cnt), 32'd1);

    // Exhaustive back-to-back sweep against the closed-form model.
    for (int i = 0; i < 32; i++) begin
      step(1'b1, 5'(i));
      check($sformatf("sweep_z_%0d", i), 32'(z), 32'(ref_z(5'(i))));
      check($sformatf("sweep_cnt_%0d", i), 32'(ones_cnt), ref_cnt(5'(i)));
      check($sformatf("sweep_valid_%0d", i), 32'(out_valid), 32'd1);
    end

    // Idle behaviour after a valid idx=16.
    step(1'b1, 5'd16);
    check("idle_pre_z", 32'(z), 32'd1);
    for (int k = 0; k < 3; k++) begin
      step(1'b0, 5'd0);
      check($sformatf("idle_valid_%0d", k), 32'(out_valid), 32'd0);
      check($sformatf("idle_z_%0d", k), 32'(z), TB_HOLD_IDLE ? 32'd1 : 32'(TB_RESET_Z));
      check($sformatf("idle_cnt_%0d", k), 32'(ones_cnt), TB_HOLD_IDLE ? 32'd1 : 32'd0);
    end

`ifdef EQUATION_PROG_EN
    // Table load coincident with an evaluation uses the old table.
    cfg_we = 1'b1;
    cfg_tt = 32'hFFFF_FFFF;
    step(1'b1, 5'd0);
    check("prog_same_cycle_z", 32'(z), 32'd0);
    cfg_we = 1'b0;
    step(1'b1, 5'd0);
    check("prog_new_table_z", 32'(z), 32'd1);
    // Reset restores the fixed equation.
    rst_n = 1'b0;
    step(1'b0, 5'd0);
    rst_n = 1'b1;
    step(1'b1, 5'd0);
    check("prog_reset_idx0", 32'(z), 32'd0);
    step(1'b1, 5'd24);
    check("prog_reset_idx24", 32'(z), 32'd0);
    step(1'b1, 5'd6);
    check("prog_reset_idx6", 32'(z), 32'd1);
`endif

    in_valid = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
